miner_dispatch: RTL and testbench

MINER_DISPATCH -- requirements
Module: miner_dispatch

---
 rtl/miner_dispatch_if.sv | 55 +++++
 rtl/miner_dispatch.sv | 243 ++++++++++++++++++++++++
 tb/tb_miner_dispatch.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_dispatch_if.sv
// Job/result bundle between a miner host and the lane dispatcher.
// The dispatcher uses the slave view; the host/environment uses the master view.
interface miner_dispatch_if #(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = 32
);
    localparam int CID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // job offer
    logic                          work_valid;
    logic                          work_ready;
    logic [511:0]                  blk1;
    logic [95:0]                   blk2;
    logic [NONCE_W-1:0]            nonce_start;
    logic                          abort;

    // lane side
    logic [511:0]                  work_blk1;
    logic [95:0]                   work_blk2;
    logic [NUM_CORES-1:0]          core_start;
    logic                          core_abort;
    logic [NUM_CORES*NONCE_W-1:0]  core_base;
    logic [NUM_CORES*NONCE_W-1:0]  core_last;
    logic [NUM_CORES-1:0]          core_done;
    logic [NUM_CORES-1:0]          core_found;
    logic [NUM_CORES*NONCE_W-1:0]  core_nonce;

    // result stream
    logic                          res_valid;
    logic                          res_ready;
    logic [NONCE_W-1:0]            res_nonce;
    logic [CID_W-1:0]              res_core;
    logic                          res_exhausted;
    logic                          res_lost;

    // status lamps
    logic                          led_processing;
    logic                          led_found;

    modport slave (
        input  work_valid, blk1, blk2, nonce_start, abort,
        input  core_done, core_found, core_nonce, res_ready,
        output work_ready, work_blk1, work_blk2, core_start, core_abort,
        output core_base, core_last, res_valid, res_nonce, res_core,
        output res_exhausted, res_lost, led_processing, led_found
    );

    modport master (
        output work_valid, blk1, blk2, nonce_start, abort,
        output core_done, core_found, core_nonce, res_ready,
        input  work_ready, work_blk1, work_blk2, core_start, core_abort,
        input  core_base, core_last, res_valid, res_nonce, res_core,
        input  res_exhausted, res_lost, led_processing, led_found
    );
endinterface

// File: rtl/miner_dispatch.sv
// Splits the nonce space of a job across NUM_CORES hashing lanes, collects
// found nonces into per-lane slots and streams them out round-robin, followed
// by an end-of-job marker once every lane reports its range exhausted.
module miner_dispatch #(
    parameter int NUM_CORES     = 4,
    parameter int NONCE_W       = 32,
    parameter int STOP_ON_FIRST = 0
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    miner_dispatch_if.slave bus
);
    localparam int LOG2_NC = $clog2(NUM_CORES);
    localparam int CID_W   = (NUM_CORES > 1) ? LOG2_NC : 1;
    // SIZE - 1, where SIZE = 2^NONCE_W / NUM_CORES
    localparam logic [NONCE_W-1:0] SIZE_M1 = {NONCE_W{1'b1}} >> LOG2_NC;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FLUSH} state_t;

    state_t               state_q, state_d;
    logic [NUM_CORES-1:0] pending_q, pending_d;
    logic [NUM_CORES-1:0] done_q, done_d;
    logic [CID_W-1:0]     ptr_q, ptr_d;
    logic                 res_valid_q, res_valid_d;
    logic [NONCE_W-1:0]   res_nonce_q, res_nonce_d;
    logic [CID_W-1:0]     res_core_q, res_core_d;
    logic                 res_exh_q, res_exh_d;
    logic                 res_lost_q, res_lost_d;
    logic                 led_found_q, led_found_d;
    logic                 core_abort_q, core_abort_d;
    logic [511:0]         work_blk1_q;
    logic [95:0]          work_blk2_q;

    logic                 accept;
    logic [NUM_CORES-1:0] capture_en;
    logic                 grant_valid;
    logic [CID_W-1:0]     grant;
    logic [NONCE_W-1:0]   slot_all [NUM_CORES];

    assign accept = (state_q == S_IDLE) && bus.work_valid;

    // Job header latch; held for the lanes until the next job is accepted.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            work_blk1_q <= '0;
            work_blk2_q <= '0;
        end else if (accept) begin
            work_blk1_q <= bus.blk1;
            work_blk2_q <= bus.blk2;
        end
    end

    // Per-lane nonce range and found-nonce slot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_lane
            localparam logic [NONCE_W-1:0] LANE_OFF = NONCE_W'(gi) << (NONCE_W - LOG2_NC);
            logic [NONCE_W-1:0] base_q;
            logic [NONCE_W-1:0] last_q;
            logic [NONCE_W-1:0] slot_q;

            // Range computed straight from the offered offset so it is valid in START.
            always_ff @(posedge CLOCK_50 or negedge reset) begin
                if (!reset) begin
                    base_q <= '0;
                    last_q <= '0;
                end else if (accept) begin
                    base_q <= bus.nonce_start + LANE_OFF;
                    last_q <= bus.nonce_start + LANE_OFF + SIZE_M1;
                end
            end

            // Capture the lane's nonce when its found pulse is accepted into the slot.
            always_ff @(posedge CLOCK_50 or negedge reset) begin
                if (!reset) begin
                    slot_q <= '0;
                end else if (capture_en[gi]) begin
                    slot_q <= bus.core_nonce[gi*NONCE_W +: NONCE_W];
                end
            end

            assign slot_all[gi] = slot_q;
            assign bus.core_base[gi*NONCE_W +: NONCE_W] = base_q;
            assign bus.core_last[gi*NONCE_W +: NONCE_W] = last_q;
        end
    endgenerate

    // Round-robin pick among pending slots, starting just after the last grant.
    always_comb begin : p_arb
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant       = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % NUM_CORES;
            if (pending_q[idx]) begin
                grant_valid = 1'b1;
                grant       = CID_W'(idx);
            end
        end
    end

    // Next-state and result-register logic.
    always_comb begin : p_next
        logic load_ok;
        logic consumed;
        logic unload;
        state_d      = state_q;
        pending_d    = pending_q;
        done_d       = done_q;
        ptr_d        = ptr_q;
        res_valid_d  = res_valid_q;
        res_nonce_d  = res_nonce_q;
        res_core_d   = res_core_q;
        res_exh_d    = res_exh_q;
        res_lost_d   = res_lost_q;
        led_found_d  = led_found_q;
        core_abort_d = 1'b0;
        capture_en   = '0;
        unload       = 1'b0;

        load_ok  = !res_valid_q || bus.res_ready;
        consumed = res_valid_q && bus.res_ready;

        // Handshake on the output register runs in every state.
        if (consumed) begin
            res_valid_d = 1'b0;
            if (!res_exh_q) begin
                led_found_d = ~led_found_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.work_valid) begin
                    pending_d  = '0;
                    done_d     = '0;
                    res_lost_d = 1'b0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bus.abort) begin
                    core_abort_d = 1'b1;
                    pending_d    = '0;
                    state_d      = S_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    core_abort_d = 1'b1;
                    pending_d    = '0;
                    state_d      = S_FLUSH;
                end else if ((STOP_ON_FIRST != 0) && consumed && !res_exh_q) begin
                    // first found result has been taken: stop every lane
                    core_abort_d = 1'b1;
                    pending_d    = '0;
                    state_d      = S_FLUSH;
                end else begin
                    if (load_ok && grant_valid) begin
                        unload           = 1'b1;
                        res_valid_d      = 1'b1;
                        res_nonce_d      = slot_all[grant];
                        res_core_d       = grant;
                        res_exh_d        = 1'b0;
                        pending_d[grant] = 1'b0;
                        ptr_d            = CID_W'((int'(grant) + 1) % NUM_CORES);
                    end else if (load_ok && (&done_q) && (pending_q == '0) && (bus.core_found == '0)) begin
                        res_valid_d = 1'b1;
                        res_nonce_d = '0;
                        res_core_d  = '0;
                        res_exh_d   = 1'b1;
                        state_d     = S_IDLE;
                    end
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (bus.core_found[i]) begin
                            // a full slot only frees up if it is being unloaded right now
                            if (pending_q[i] && !(unload && (grant == CID_W'(i)))) begin
                                res_lost_d = 1'b1;
                            end else begin
                                pending_d[i]  = 1'b1;
                                capture_en[i] = 1'b1;
                            end
                        end
                        if (bus.core_done[i]) begin
                            done_d[i] = 1'b1;
                        end
                    end
                end
            end
            S_FLUSH: begin
                if (!res_valid_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result state register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            done_q       <= '0;
            ptr_q        <= '0;
            res_valid_q  <= 1'b0;
            res_nonce_q  <= '0;
            res_core_q   <= '0;
            res_exh_q    <= 1'b0;
            res_lost_q   <= 1'b0;
            led_found_q  <= 1'b0;
            core_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            done_q       <= done_d;
            ptr_q        <= ptr_d;
            res_valid_q  <= res_valid_d;
            res_nonce_q  <= res_nonce_d;
            res_core_q   <= res_core_d;
            res_exh_q    <= res_exh_d;
            res_lost_q   <= res_lost_d;
            led_found_q  <= led_found_d;
            core_abort_q <= core_abort_d;
        end
    end

    assign bus.work_ready     = (state_q == S_IDLE);
    assign bus.work_blk1      = work_blk1_q;
    assign bus.work_blk2      = work_blk2_q;
    assign bus.core_start     = {NUM_CORES{state_q == S_START}};
    assign bus.core_abort     = core_abort_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_nonce      = res_nonce_q;
    assign bus.res_core       = res_core_q;
    assign bus.res_exhausted  = res_exh_q;
    assign bus.res_lost       = res_lost_q;
    assign bus.led_processing = (state_q == S_START) || (state_q == S_RUN);
    assign bus.led_found      = led_found_q;
endmodule

// File: tb/tb_miner_dispatch.sv
// Directed bench for miner_dispatch: one instance streaming all results and
// one instance that stops after the first found result.
module tb_miner_dispatch;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] nonce;
        logic [1:0]  core;
        logic        exh;
    } res_t;

    res_t q0[$];
    res_t q1[$];

    miner_dispatch_if #(.NUM_CORES(4), .NONCE_W(32)) if0 ();
    miner_dispatch_if #(.NUM_CORES(4), .NONCE_W(32)) if1 ();

    miner_dispatch #(.NUM_CORES(4), .NONCE_W(32), .STOP_ON_FIRST(0)) dut0 (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (if0)
    );

    miner_dispatch #(.NUM_CORES(4), .NONCE_W(32), .STOP_ON_FIRST(1)) dut1 (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t mk(input logic [31:0] nonce, input logic [1:0] core, input logic exh);
        res_t r;
        r.nonce = nonce;
        r.core  = core;
        r.exh   = exh;
        return r;
    endfunction

    // Scoreboard for the streaming instance.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && if0.res_valid && if0.res_ready) begin
            $display("dut0 result core=%0d nonce=%h exhausted=%0b lost=%0b",
                     if0.res_core, if0.res_nonce, if0.res_exhausted, if0.res_lost);
            if (q0.size() == 0) begin
                chk("dut0_unexpected_result", if0.res_valid, 1'b0);
            end else begin
                e = q0.pop_front();
                chk("dut0_res_nonce", if0.res_nonce, e.nonce);
                chk("dut0_res_core", if0.res_core, e.core);
                chk("dut0_res_exhausted", if0.res_exhausted, e.exh);
            end
        end
    end

    // Scoreboard for the stop-on-first instance.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && if1.res_valid && if1.res_ready) begin
            $display("dut1 result core=%0d nonce=%h exhausted=%0b lost=%0b",
                     if1.res_core, if1.res_nonce, if1.res_exhausted, if1.res_lost);
            if (q1.size() == 0) begin
                chk("dut1_unexpected_result", if1.res_valid, 1'b0);
            end else begin
                e = q1.pop_front();
                chk("dut1_res_nonce", if1.res_nonce, e.nonce);
                chk("dut1_res_core", if1.res_core, e.core);
                chk("dut1_res_exhausted", if1.res_exhausted, e.exh);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        if0.work_valid = 0; if0.blk1 = '0; if0.blk2 = '0; if0.nonce_start = '0; if0.abort = 0;
        if0.core_done = '0; if0.core_found = '0; if0.core_nonce = '0; if0.res_ready = 0;
        if1.work_valid = 0; if1.blk1 = '0; if1.blk2 = '0; if1.nonce_start = '0; if1.abort = 0;
        if1.core_done = '0; if1.core_found = '0; if1.core_nonce = '0; if1.res_ready = 0;
        tick(); tick();

        // reset state
        chk("rst_res_valid", if0.res_valid, 0);
        chk("rst_core_start", if0.core_start, 0);
        chk("rst_core_abort", if0.core_abort, 0);
        chk("rst_core_last3", if0.core_last[96 +: 32], 0);
        chk("rst_work_blk2", if0.work_blk2, 0);
        chk("rst_led_found", if0.led_found, 0);
        chk("rst_res_lost", if0.res_lost, 0);
        chk("rst_led_proc", if0.led_processing, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_work_ready", if0.work_ready, 1);

        // job with offset 0: lane ranges and start pulse
        if0.blk1 = {16{32'hA5A5_0001}};
        if0.blk2 = 96'h0123_4567_89AB_CDEF_1357_9BDF;
        if0.nonce_start = 32'h0;
        if0.work_valid = 1;
        tick();
        if0.work_valid = 0;
        chk("start_core_start", if0.core_start, 4'hF);
        chk("start_base0", if0.core_base[0 +: 32], 32'h0000_0000);
        chk("start_base1", if0.core_base[32 +: 32], 32'h4000_0000);
        chk("start_base2", if0.core_base[64 +: 32], 32'h8000_0000);
        chk("start_base3", if0.core_base[96 +: 32], 32'hC000_0000);
        chk("start_last3", if0.core_last[96 +: 32], 32'hFFFF_FFFF);
        chk("start_last0", if0.core_last[0 +: 32], 32'h3FFF_FFFF);
        chk("start_work_blk2", if0.work_blk2, 96'h0123_4567_89AB_CDEF_1357_9BDF);
        chk("start_work_ready", if0.work_ready, 0);
        chk("start_led_proc", if0.led_processing, 1);
        tick();
        chk("run_core_start_off", if0.core_start, 0);

        // simultaneous finds on lanes 1 and 3, output always ready
        if0.res_ready = 1;
        if0.core_found = 4'b1010;
        if0.core_nonce = {32'hC000_1234, 32'h0, 32'h1111_0001, 32'h0};
        q0.push_back(mk(32'h1111_0001, 2'd1, 1'b0));
        q0.push_back(mk(32'hC000_1234, 2'd3, 1'b0));
        tick();
        if0.core_found = '0;
        if0.core_nonce = '0;
        tick();
        chk("rr_first_core", if0.res_core, 1);
        tick();
        chk("rr_second_valid", if0.res_valid, 1);
        chk("rr_second_core", if0.res_core, 3);
        chk("rr_led_after_one", if0.led_found, 1);
        tick();
        chk("rr_led_after_two", if0.led_found, 0);
        chk("rr_drained", if0.res_valid, 0);

        // lane 2 finds while the output is stalled; third find is dropped
        if0.res_ready = 0;
        if0.core_found = 4'b0100;
        if0.core_nonce = {32'h0, 32'h2222_0001, 32'h0, 32'h0};
        q0.push_back(mk(32'h2222_0001, 2'd2, 1'b0));
        tick();
        if0.core_found = '0;
        tick();
        if0.core_found = 4'b0100;
        if0.core_nonce = {32'h0, 32'h2222_0002, 32'h0, 32'h0};
        q0.push_back(mk(32'h2222_0002, 2'd2, 1'b0));
        tick();
        if0.core_nonce = {32'h0, 32'h2222_0003, 32'h0, 32'h0};
        tick();
        if0.core_found = '0;
        if0.core_nonce = '0;
        chk("lost_flag", if0.res_lost, 1);
        chk("stall_valid", if0.res_valid, 1);
        chk("stall_nonce", if0.res_nonce, 32'h2222_0001);
        tick();
        chk("stall_hold_nonce", if0.res_nonce, 32'h2222_0001);
        if0.res_ready = 1;
        for (int k = 0; k < 20 && q0.size() > 0; k++) tick();
        chk("stall_drain_left", q0.size(), 0);
        chk("lost_sticky_run", if0.res_lost, 1);

        // all lanes exhausted without a find
        if0.core_done = 4'hF;
        q0.push_back(mk(32'h0, 2'd0, 1'b1));
        tick();
        if0.core_done = '0;
        tick();
        chk("exh_marker", if0.res_exhausted, 1);
        chk("exh_work_ready", if0.work_ready, 1);
        chk("exh_led_proc", if0.led_processing, 0);
        tick();
        chk("exh_consumed", if0.res_valid, 0);
        chk("exh_led_found", if0.led_found, 0);
        chk("lost_sticky_idle", if0.res_lost, 1);

        // wrapped ranges with offset 0xF0000000
        if0.nonce_start = 32'hF000_0000;
        if0.work_valid = 1;
        tick();
        if0.work_valid = 0;
        chk("wrap_base1", if0.core_base[32 +: 32], 32'h3000_0000);
        chk("wrap_last0", if0.core_last[0 +: 32], 32'h2FFF_FFFF);
        chk("wrap_base3", if0.core_base[96 +: 32], 32'hB000_0000);
        chk("wrap_last3", if0.core_last[96 +: 32], 32'hEFFF_FFFF);
        chk("wrap_lost_cleared", if0.res_lost, 0);
        tick();

        // pointer sits after lane 2, so lane 3 wins over lane 0
        if0.core_found = 4'b1001;
        if0.core_nonce = {32'hEEEE_0003, 32'h0, 32'h0, 32'hF000_0007};
        q0.push_back(mk(32'hEEEE_0003, 2'd3, 1'b0));
        q0.push_back(mk(32'hF000_0007, 2'd0, 1'b0));
        tick();
        if0.core_found = '0;
        if0.core_nonce = '0;
        for (int k = 0; k < 20 && q0.size() > 0; k++) tick();
        chk("rr_wrap_drain_left", q0.size(), 0);

        // abort mid-run discards a pending find
        if0.res_ready = 0;
        if0.core_found = 4'b0001;
        if0.core_nonce = {32'h0, 32'h0, 32'h0, 32'hDEAD_0000};
        tick();
        if0.core_found = '0;
        if0.abort = 1;
        tick();
        if0.abort = 0;
        chk("abort_pulse", if0.core_abort, 1);
        chk("abort_led_proc", if0.led_processing, 0);
        tick();
        chk("abort_pulse_off", if0.core_abort, 0);
        chk("abort_work_ready", if0.work_ready, 1);
        if0.res_ready = 1;
        tick(); tick();
        chk("abort_no_result", if0.res_valid, 0);

        // stop-on-first instance: first consumed find ends the job
        if1.nonce_start = 32'h0;
        if1.work_valid = 1;
        tick();
        if1.work_valid = 0;
        chk("sof_core_start", if1.core_start, 4'hF);
        tick();
        if1.res_ready = 1;
        if1.core_found = 4'b0101;
        if1.core_nonce = {32'h0, 32'h8000_00BB, 32'h0, 32'h0000_00AA};
        q1.push_back(mk(32'h0000_00AA, 2'd0, 1'b0));
        tick();
        if1.core_found = '0;
        if1.core_nonce = '0;
        tick();
        chk("sof_first_core", if1.res_core, 0);
        tick();
        chk("sof_abort_pulse", if1.core_abort, 1);
        chk("sof_no_second", if1.res_valid, 0);
        tick();
        chk("sof_abort_off", if1.core_abort, 0);
        chk("sof_work_ready", if1.work_ready, 1);
        chk("sof_led_found", if1.led_found, 1);
        if1.core_found = 4'b0010;
        if1.core_nonce = {32'h0, 32'h0, 32'h4000_0011, 32'h0};
        tick();
        if1.core_found = '0;
        tick(); tick(); tick();
        chk("sof_late_found_ignored", if1.res_valid, 0);
        chk("sof_queue_empty", q1.size(), 0);

        // stop-on-first instance: abort input mid-run
        if1.work_valid = 1;
        tick();
        if1.work_valid = 0;
        tick();
        if1.abort = 1;
        tick();
        if1.abort = 0;
        chk("sof_ext_abort_pulse", if1.core_abort, 1);
        tick();
        chk("sof_ext_abort_off", if1.core_abort, 0);
        chk("sof_ext_work_ready", if1.work_ready, 1);
        tick(); tick();
        chk("sof_ext_no_result", if1.res_valid, 0);
        chk("dut0_queue_empty", q0.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
